// File: rtl/exp_cmd_sequencer.sv
`timescale 1ns/1ps
// exp_cmd_sequencer
//   Streams five N_BITS operands (x, exponent, modulus, Rmodm, Rsquaredmodm),
//   least-significant word first, into registers that feed a modular
//   exponentiation core. It then holds the start level until the core reports
//   done, captures A_result, and streams the result back out LSW first.
//
// Ports
//   clk, resetn                  clock / asynchronous active-low reset
//   s_data, s_valid, s_ready     operand load stream (80 words)
//   cfg_multiply                 mode bit, latched on the final load word
//   startExponentiation          start level to core (START and WAIT)
//   multiplication_enable        latched mode to core
//   x, exponent, modulus,
//   Rmodm, Rsquaredmodm          registered operands to core
//   done, A_result               core completion level and result
//   m_data, m_valid, m_ready,
//   m_last                       result stream (16 words)
//   busy                         high in every state except LOAD
module exp_cmd_sequencer #(
    parameter int unsigned N_BITS  = 512,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned N_WORDS = N_BITS / WORD_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              cfg_multiply,
    output logic              startExponentiation,
    output logic              multiplication_enable,
    output logic [N_BITS-1:0] x,
    output logic [N_BITS-1:0] exponent,
    output logic [N_BITS-1:0] modulus,
    output logic [N_BITS-1:0] Rmodm,
    output logic [N_BITS-1:0] Rsquaredmodm,
    input  logic              done,
    input  logic [N_BITS-1:0] A_result,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);

    localparam int unsigned WIDX       = $clog2(N_WORDS);
    localparam logic [6:0]  LAST_LOAD  = 7'(5 * N_WORDS - 1);
    localparam logic [6:0]  LAST_DRAIN = 7'(N_WORDS - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [6:0]        r_cnt;
    logic [N_BITS-1:0] r_x, r_exp, r_mod, r_rmodm, r_r2modm, r_result;
    logic              r_mul;
    logic              w_s_hs;
    logic              w_m_hs;
    logic [WIDX-1:0]   w_word;
    logic [6-WIDX:0]   w_op;

    // Low counter bits pick the word, high bits pick the operand.
    assign w_word = r_cnt[WIDX-1:0];
    assign w_op   = r_cnt[6:WIDX];

    always_comb begin
        w_next_state        = r_state;
        w_s_hs              = 1'b0;
        w_m_hs              = 1'b0;
        s_ready             = 1'b0;
        m_valid             = 1'b0;
        m_last              = 1'b0;
        startExponentiation = 1'b0;
        busy                = 1'b1;
        case (r_state)
            S_LOAD: begin
                busy    = 1'b0;
                // Gated by resetn so s_ready stays low while reset is held.
                s_ready = resetn;
                w_s_hs  = s_valid & resetn;
                if (w_s_hs && r_cnt == LAST_LOAD)
                    w_next_state = S_START;
            end
            S_START: begin
                startExponentiation = 1'b1;
                w_next_state        = S_WAIT;
            end
            S_WAIT: begin
                startExponentiation = 1'b1;
                if (done)
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                m_valid = 1'b1;
                m_last  = (r_cnt == LAST_DRAIN);
                w_m_hs  = m_ready;
                if (w_m_hs && r_cnt == LAST_DRAIN)
                    w_next_state = S_LOAD;
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_mul    <= 1'b0;
            r_x      <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_rmodm  <= '0;
            r_r2modm <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_s_hs) begin
                case (w_op)
                    3'd0: r_x[w_word*WORD_W +: WORD_W]      <= s_data;
                    3'd1: r_exp[w_word*WORD_W +: WORD_W]    <= s_data;
                    3'd2: r_mod[w_word*WORD_W +: WORD_W]    <= s_data;
                    3'd3: r_rmodm[w_word*WORD_W +: WORD_W]  <= s_data;
                    3'd4: r_r2modm[w_word*WORD_W +: WORD_W] <= s_data;
                    default: ;
                endcase
                if (r_cnt == LAST_LOAD) begin
                    r_cnt <= '0;
                    r_mul <= cfg_multiply;
                end else begin
                    r_cnt <= r_cnt + 7'd1;
                end
            end
            if (r_state == S_WAIT && done)
                r_result <= A_result;
            if (w_m_hs)
                r_cnt <= (r_cnt == LAST_DRAIN) ? '0 : r_cnt + 7'd1;
        end
    end

    assign m_data                = r_result[w_word*WORD_W +: WORD_W];
    assign multiplication_enable = r_mul;
    assign x                     = r_x;
    assign exponent              = r_exp;
    assign modulus               = r_mod;
    assign Rmodm                 = r_rmodm;
    assign Rsquaredmodm          = r_r2modm;

endmodule

// File: doc/exp_cmd_sequencer.md
EXP_CMD_SEQUENCER -- requirements
Module: exp_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: N_BITS, 512, operand/result width; WORD_W, 32, stream word width; N_WORDS, N_BITS/WORD_W = 16, words per operand.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 s_data  input  WORD_W  operand load word.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_ready  output  1  sequencer accepts s_data this cycle.
REQ-007 cfg_multiply  input  1  mode bit, forwarded to multiplication_enable.
REQ-008 startExponentiation  output  1  start level to exponentiation core.
REQ-009 multiplication_enable  output  1  registered mode to core.
REQ-010 x, exponent, modulus, Rmodm, Rsquaredmodm  output  N_BITS each  registered operands to core.
REQ-011 done  input  1  core completion level.
REQ-012 A_result  input  N_BITS  core result, valid while done=1.
REQ-013 m_data  output  WORD_W  result word.
REQ-014 m_valid  output  1  m_data valid.
REQ-015 m_ready  input  1  downstream accepts m_data.
REQ-016 m_last  output  1  marks final result word.
REQ-017 busy  output  1  high in every state except LOAD.

Function
REQ-018 States SHALL be LOAD, START, WAIT, DRAIN; a 7-bit word counter cnt SHALL index words.
REQ-019 LOAD: s_ready=1; each s_valid&s_ready handshake writes s_data into word cnt%16 of operand cnt/16, then cnt increments.
REQ-020 Operand order SHALL be x, exponent, modulus, Rmodm, Rsquaredmodm (80 words total), least-significant word first.
REQ-021 cfg_multiply SHALL be sampled into multiplication_enable on the handshake of word 79.
REQ-022 Handshake of word 79 in cycle T: state=START and startExponentiation=1 from T+1; s_ready=0 from T+1; cnt cleared.
REQ-023 START SHALL last one cycle, then go to WAIT with startExponentiation held at 1.
REQ-024 WAIT: startExponentiation held at 1 until the first cycle with done=1; that cycle A_result is captured into a 512-bit result register.
REQ-025 done=1 sampled at edge D: startExponentiation=0, state=DRAIN and m_valid=1 from D+1.
REQ-026 done=1 in START SHALL be ignored.
REQ-027 Operand outputs SHALL remain stable from end of LOAD until DRAIN completes; they change only on LOAD handshakes.
REQ-028 DRAIN: m_data = result word cnt (LSW first); on m_valid&m_ready cnt increments; m_last=1 when cnt=15.
REQ-029 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold unchanged.
REQ-030 Handshake on word 15 SHALL return state to LOAD and clear cnt; m_valid=0 and s_ready=1 in the next cycle.
REQ-031 s_valid outside LOAD SHALL be ignored (no write, no counter change).
REQ-032 m_valid SHALL be 0 in every state except DRAIN.

Reset
REQ-033 resetn=0 SHALL immediately force state=LOAD, cnt=0, startExponentiation=0, multiplication_enable=0, m_valid=0, m_last=0, busy=0, s_ready=0 while resetn=0.
REQ-034 Reset SHALL clear all operand and result registers to 0.
REQ-035 Reset mid-LOAD, WAIT or DRAIN SHALL abandon the operation; partially loaded words are discarded; the next load starts at word 0.
REQ-036 s_ready SHALL rise in the first cycle after resetn deasserts.

Verification
REQ-037 Load x=0x87b21d93...b9589, exponent=0xaf, modulus=0xd97a2188...9c5885, Rmodm=0x2685de77...63a77b, Rsquaredmodm=0x733f6233...ca57ad, cfg_multiply=0, against the real core -> 16 result words reassemble to 0xbdb2a4a4...7400189, m_last only on word 16.
REQ-038 Core model asserts done 40 cycles after start -> startExponentiation high exactly 41 cycles, m_valid rises the cycle after done.
REQ-039 Random s_valid gaps (~50%) and m_ready backpressure (~50%) -> operands bit-exact with reference values, m_data stable under stall, no word lost or duplicated.
REQ-040 Pulse resetn low during WAIT, then reload with exponent=0x01 -> all outputs reset, second run result equals x mod modulus path from core model, no stale words.
REQ-041 s_valid held high during START/WAIT/DRAIN with pattern 0xdeadbeef -> no operand register changes, s_ready=0 throughout.
REQ-042 cfg_multiply=1 on word 79 then toggled -> multiplication_enable=1 for the whole operation, unchanged by later cfg_multiply edges.
